// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//   Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
//   Each transaction takes three cycles: IDLE picks a winner, GRANT loads the
//   winner's data into q (or aborts if the winner dropped req), and ACK
//   pulses the winner's ack while q shows the new value.
//
// Ports
//   clk      clock, all state updates on the rising edge
//   rst      asynchronous active-low reset
//   req      [NREQ]         per-requester level write request
//   wdata    [NREQ*WIDTH]   requester i data at [i*WIDTH +: WIDTH]
//   gnt      [NREQ]         registered one-hot grant, high during GRANT
//   ack      [NREQ]         registered one-hot ack, high during ACK
//   q        [WIDTH]        shared register contents
//   q_owner  [$clog2(NREQ)] index of the last requester that wrote q
//   busy                    high whenever the sequencer is not in IDLE
module shared_reg_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      q,
    output logic [PW-1:0]         q_owner,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr;       // highest-priority requester
    logic [PW-1:0]   win;       // winner latched for the GRANT cycle
    logic [PW-1:0]   scan_idx;
    logic            scan_hit;
    logic            do_write;
    logic            do_grant;
    int              idx;

    // Round-robin scan: first set req bit at or above ptr, wrapping to 0.
    always_comb begin
        scan_idx = '0;
        scan_hit = 1'b0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (!scan_hit && req[idx]) begin
                scan_hit = 1'b1;
                scan_idx = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_write  = 1'b0;
        do_grant  = 1'b0;
        case (state)
            IDLE: begin
                if (scan_hit) begin
                    do_grant  = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // Winner must still be requesting; otherwise abort with no
                // write and no pointer movement.
                if (req[win]) begin
                    do_write  = 1'b1;
                    state_nxt = ACK;
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // gnt and ack are each live for exactly one state, so they are simply
    // recomputed every edge and fall back to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt     <= '0;
            ack     <= '0;
            q       <= '0;
            q_owner <= '0;
            ptr     <= '0;
            win     <= '0;
        end else begin
            gnt <= do_grant ? (NREQ'(1) << scan_idx) : '0;
            ack <= do_write ? (NREQ'(1) << win) : '0;
            if (do_grant)
                win <= scan_idx;
            if (do_write) begin
                q       <= wdata[win*WIDTH +: WIDTH];
                q_owner <= win;
                ptr     <= (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
module tb_shared_reg_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int PW    = $clog2(NREQ);
    localparam int VW    = 2*NREQ + WIDTH + PW + 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] wdata = '0;
    logic [NREQ-1:0]       gnt, ack;
    logic [WIDTH-1:0]      q;
    logic [PW-1:0]         q_owner;
    logic                  busy;

    int n_cmp  = 0;
    int n_fail = 0;

    shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata),
        .gnt(gnt), .ack(ack), .q(q), .q_owner(q_owner), .busy(busy)
    );

    always #5 clk = ~clk;

    // Transaction-level reference: phase 0 = waiting, 1 = granted, 2 = acked.
    int m_phase, m_ptr, m_win, m_q, m_own;

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_win = 0; m_q = 0; m_own = 0;
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [VW-1:0] expv();
        logic [NREQ-1:0] eg, ea;
        eg = (m_phase == 1) ? NREQ'(1 << m_win) : '0;
        ea = (m_phase == 2) ? NREQ'(1 << m_own) : '0;
        return {eg, ea, WIDTH'(m_q), PW'(m_own), m_phase != 0};
    endfunction

    // One rising edge; advance the model with the inputs seen at that edge.
    task automatic tick();
        int w;
        @(posedge clk);
        if (!rst) model_reset();
        else begin
            case (m_phase)
                0: begin
                    w = rr_pick(req, m_ptr);
                    if (w >= 0) begin m_win = w; m_phase = 1; end
                end
                1: begin
                    if (req[m_win]) begin
                        m_q = int'(wdata[m_win*WIDTH +: WIDTH]);
                        m_own = m_win;
                        m_ptr = (m_win + 1) % NREQ;
                        m_phase = 2;
                    end else m_phase = 0;
                end
                default: m_phase = 0;
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        wdata = {$urandom, $urandom};
        req = 4'b1111;
        rst = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({gnt, ack, q, q_owner, busy} !== '0) begin
            n_fail++; $display("FAIL reset_async: got %h want 0", {gnt, ack, q, q_owner, busy});
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if ({gnt, ack, q, q_owner, busy} !== '0) begin
                n_fail++; $display("FAIL reset_hold: got %h want 0", {gnt, ack, q, q_owner, busy});
            end
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin
            n_fail++; $display("FAIL reset_first_gnt: got %b want 0001", gnt);
        end
        req = '0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if ({gnt, ack, q, q_owner, busy} !== expv()) begin
                n_fail++; $display("FAIL reset_abort: got %h want %h", {gnt, ack, q, q_owner, busy}, expv());
            end
        end
    endtask

    task automatic test_single();
        wdata = {$urandom, $urandom};
        wdata[2*WIDTH +: WIDTH] = 8'hA5;
        req = 4'b0100;
        tick();
        n_cmp++;
        if (gnt !== 4'b0100 || ack !== '0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_gnt: got gnt=%b ack=%b busy=%b want 0100/0000/1", gnt, ack, busy);
        end
        tick();
        n_cmp++;
        if (ack !== 4'b0100 || gnt !== '0 || q !== 8'hA5 || q_owner !== 2'd2) begin
            n_fail++; $display("FAIL single_ack: got ack=%b gnt=%b q=%h own=%0d want 0100/0000/a5/2", ack, gnt, q, q_owner);
        end
        req = '0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || ack !== '0 || q !== 8'hA5) begin
            n_fail++; $display("FAIL single_idle: got busy=%b ack=%b q=%h want 0/0000/a5", busy, ack, q);
        end
    endtask

    // ptr now sits at 3 after requester 2's write.
    task automatic test_wrap();
        int order[$];
        wdata = {$urandom, $urandom};
        req = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++;
            if ({gnt, ack, q, q_owner, busy} !== expv()) begin
                n_fail++; $display("FAIL wrap_cycle: got %h want %h", {gnt, ack, q, q_owner, busy}, expv());
            end
            if (ack != '0) begin
                order.push_back(int'(q_owner));
                req = req & ~ack;
            end
        end
        n_cmp++;
        if (order.size() != 2 || order[0] != 0 || order[1] != 1) begin
            n_fail++; $display("FAIL wrap_order: got %p want '{0,1}", order);
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        logic [NREQ-1:0] reraise;
        logic [WIDTH-1:0] exp_q;
        rst = 1'b0; #1; model_reset(); rst = 1'b1;
        wdata = {$urandom, $urandom};
        req = 4'b1111;
        reraise = '0;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            tick();
            n_cmp++;
            if ({gnt, ack, q, q_owner, busy} !== expv()) begin
                n_fail++; $display("FAIL rr_cycle: got %h want %h", {gnt, ack, q, q_owner, busy}, expv());
            end
            req = req | reraise;
            reraise = '0;
            if (ack != '0) begin
                order.push_back(int'(q_owner));
                exp_q = wdata[int'(q_owner)*WIDTH +: WIDTH];
                n_cmp++;
                if (q !== exp_q) begin
                    n_fail++; $display("FAIL rr_data: got %h want %h", q, exp_q);
                end
                req = req & ~ack;
                reraise = ack;
            end
        end
        n_cmp++;
        if (order.size() != 5 || order[0] != 0 || order[1] != 1 || order[2] != 2
            || order[3] != 3 || order[4] != 0) begin
            n_fail++; $display("FAIL rr_order: got %p want '{0,1,2,3,0}", order);
        end
        req = '0;
        tick();
    endtask

    // ptr is 1 after the round-robin run ended on requester 0.
    task automatic test_abort();
        logic [WIDTH-1:0] q_before;
        q_before = q;
        wdata = {$urandom, $urandom};
        req = 4'b0010;
        tick();
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_fail++; $display("FAIL abort_gnt: got %b want 0010", gnt);
        end
        req = '0;
        tick();
        n_cmp++;
        if (gnt !== '0 || ack !== '0 || q !== q_before || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_noack: got gnt=%b ack=%b q=%h busy=%b want 0/0/%h/0", gnt, ack, q, busy, q_before);
        end
        tick();
        n_cmp++;
        if (ack !== '0 || q !== q_before) begin
            n_fail++; $display("FAIL abort_late: got ack=%b q=%h want 0/%h", ack, q, q_before);
        end
        req = 4'b1010;
        tick();
        n_cmp++;
        if (gnt !== 4'b0010) begin
            n_fail++; $display("FAIL abort_ptr: got %b want 0010", gnt);
        end
        tick();
        req = '0;
        tick();
    endtask

    task automatic test_async_reset();
        req = 4'b0100;
        wdata = {$urandom, $urandom};
        tick();
        n_cmp++;
        if (gnt !== 4'b0100) begin
            n_fail++; $display("FAIL arst_pre: got %b want 0100", gnt);
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (gnt !== '0 || q !== '0 || busy !== 1'b0 || q_owner !== '0) begin
            n_fail++; $display("FAIL arst_now: got gnt=%b q=%h busy=%b own=%0d want 0", gnt, q, busy, q_owner);
        end
        tick();
        n_cmp++;
        if (ack !== '0 || q !== '0) begin
            n_fail++; $display("FAIL arst_noack: got ack=%b q=%h want 0/0", ack, q);
        end
        rst = 1'b1;
        req = '0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req = NREQ'($urandom);
            wdata = {$urandom, $urandom};
            tick();
            n_cmp++;
            if ({gnt, ack, q, q_owner, busy} !== expv()) begin
                n_fail++; $display("FAIL random_cycle %0d: got %h want %h", c, {gnt, ack, q, q_owner, busy}, expv());
            end
            n_cmp++;
            if ((gnt & ack) != '0 || $countones(gnt) > 1 || $countones(ack) > 1) begin
                n_fail++; $display("FAIL random_onehot: got gnt=%b ack=%b want exclusive one-hot", gnt, ack);
            end
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0; #1; model_reset(); rst = 1'b1;
            end
        end
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_abort();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
